// File: rtl/semaforo_sequenciador.sv
// Timed traffic-light sequencer (PARE -> SIGA -> ATENCAO -> PARE) with a
// latched pedestrian request that shortens green and a blinking night mode.
module semaforo_sequenciador #(
   parameter int CNT_BITS   = 8,
   parameter int T_PARE     = 8,
   parameter int T_SIGA     = 10,
   parameter int T_ATENCAO  = 3,
   parameter int T_MIN_SIGA = 4,
   parameter int T_PISCA    = 2
) (
   input  logic                clk_2,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                pedestre,
   input  logic                noturno,
   output logic                pare,
   output logic                atencao,
   output logic                siga,
   output logic [CNT_BITS-1:0] tempo_restante,
   output logic                fim_fase,
   output logic                pedido_pend
);

   typedef enum logic [1:0] {
      ST_PARE,
      ST_SIGA,
      ST_ATENCAO,
      ST_NOTURNO
   } estado_t;

   localparam logic [CNT_BITS-1:0] L_PARE    = CNT_BITS'(T_PARE - 1);
   localparam logic [CNT_BITS-1:0] L_SIGA    = CNT_BITS'(T_SIGA - 1);
   localparam logic [CNT_BITS-1:0] L_ATENCAO = CNT_BITS'(T_ATENCAO - 1);
   localparam logic [CNT_BITS-1:0] L_PISCA   = CNT_BITS'(T_PISCA - 1);
   localparam logic [CNT_BITS-1:0] UM        = CNT_BITS'(1);

   // Early green exit is only possible when the minimum green is shorter than full green.
   localparam bit                  EARLY_EN  = (T_MIN_SIGA < T_SIGA);
   localparam logic [CNT_BITS-1:0] EARLY_LIM = EARLY_EN ? CNT_BITS'(T_SIGA - 1 - T_MIN_SIGA) : '0;

   estado_t             state_q, state_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                pare_q, pare_d;
   logic                atencao_q, atencao_d;
   logic                siga_q, siga_d;
   logic                fim_q, fim_d;
   logic                ped_q, ped_d;
   logic                blink_d;

   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_PARE;
         cnt_q     <= L_PARE;
         pare_q    <= 1'b1;
         atencao_q <= 1'b0;
         siga_q    <= 1'b0;
         fim_q     <= 1'b0;
         ped_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pare_q    <= pare_d;
         atencao_q <= atencao_d;
         siga_q    <= siga_d;
         fim_q     <= fim_d;
         ped_q     <= ped_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      blink_d = atencao_q;
      ped_d   = ped_q;

      if (pedestre && (state_q != ST_PARE)) begin
         ped_d = 1'b1;
      end

      // Night mode request overrides everything and ignores enable.
      if (noturno) begin
         ped_d = 1'b0;
         if (state_q != ST_NOTURNO) begin
            state_d = ST_NOTURNO;
            cnt_d   = L_PISCA;
            blink_d = 1'b1;
         end else if (enable) begin
            if (cnt_q == '0) begin
               blink_d = ~atencao_q;
               cnt_d   = L_PISCA;
            end else begin
               cnt_d = cnt_q - UM;
            end
         end
      end else if (state_q == ST_NOTURNO) begin
         state_d = ST_PARE;
         cnt_d   = L_PARE;
      end else if (enable) begin
         case (state_q)
            ST_PARE: begin
               if (cnt_q == '0) begin
                  state_d = ST_SIGA;
                  cnt_d   = L_SIGA;
               end else begin
                  cnt_d = cnt_q - UM;
               end
            end
            ST_SIGA: begin
               if ((cnt_q == '0) || (ped_q && EARLY_EN && (cnt_q <= EARLY_LIM))) begin
                  state_d = ST_ATENCAO;
                  cnt_d   = L_ATENCAO;
               end else begin
                  cnt_d = cnt_q - UM;
               end
            end
            ST_ATENCAO: begin
               if (cnt_q == '0) begin
                  state_d = ST_PARE;
                  cnt_d   = L_PARE;
               end else begin
                  cnt_d = cnt_q - UM;
               end
            end
            default: begin
               state_d = ST_PARE;
               cnt_d   = L_PARE;
            end
         endcase
      end

      // Entering PARE always clears the request, even if pedestre is set the same edge.
      if ((state_d == ST_PARE) && (state_q != ST_PARE)) begin
         ped_d = 1'b0;
      end

      pare_d    = (state_d == ST_PARE);
      siga_d    = (state_d == ST_SIGA);
      atencao_d = (state_d == ST_NOTURNO) ? blink_d : (state_d == ST_ATENCAO);
      fim_d     = (state_d != state_q);
   end

   assign pare           = pare_q;
   assign atencao        = atencao_q;
   assign siga           = siga_q;
   assign tempo_restante = cnt_q;
   assign fim_fase       = fim_q;
   assign pedido_pend    = ped_q;

endmodule

// File: tb/tb_semaforo_sequenciador.sv
// Directed self-checking bench for semaforo_sequenciador with short phase times.
module tb_semaforo_sequenciador;

   logic       clk_2 = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic       pedestre = 1'b0;
   logic       noturno = 1'b0;
   logic       pare, atencao, siga, fim_fase, pedido_pend;
   logic [7:0] tempo_restante;

   int checks = 0;
   int errors = 0;

   semaforo_sequenciador #(
      .CNT_BITS  (8),
      .T_PARE    (4),
      .T_SIGA    (6),
      .T_ATENCAO (2),
      .T_MIN_SIGA(3),
      .T_PISCA   (2)
   ) dut (
      .clk_2         (clk_2),
      .reset_n       (reset_n),
      .enable        (enable),
      .pedestre      (pedestre),
      .noturno       (noturno),
      .pare          (pare),
      .atencao       (atencao),
      .siga          (siga),
      .tempo_restante(tempo_restante),
      .fim_fase      (fim_fase),
      .pedido_pend   (pedido_pend)
   );

   always #5 clk_2 = ~clk_2;

   // light code: 0 = pare, 1 = siga, 2 = atencao -> {pare, atencao, siga}
   function automatic logic [2:0] luz(input int c);
      case (c)
         0:       return 3'b100;
         1:       return 3'b001;
         default: return 3'b010;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk_2);
      @(negedge clk_2);
   endtask

   task automatic do_reset();
      @(negedge clk_2);
      reset_n  = 1'b0;
      enable   = 1'b0;
      pedestre = 1'b0;
      noturno  = 1'b0;
      @(negedge clk_2);
      @(negedge clk_2);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [12:0] obs, exp;
      @(negedge clk_2);
      reset_n = 1'b0;
      #1;
      obs = {pare, atencao, siga, fim_fase, pedido_pend, tempo_restante};
      exp = {3'b100, 1'b0, 1'b0, 8'd3};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL reset_state: got %h expected %h", obs, exp);
      end
   endtask

   task automatic test_normal_cycle();
      int lt [17];
      int ct [17];
      logic [11:0] obs, exp;
      logic f;
      lt = '{0,0,0,0,1,1,1,1,1,1,2,2,0,0,0,0,1};
      ct = '{3,2,1,0,5,4,3,2,1,0,1,0,3,2,1,0,5};
      do_reset();
      enable = 1'b1;
      for (int k = 0; k < 17; k++) begin
         if (k > 0) tick();
         f   = (k > 0) && (lt[k] != lt[k-1]);
         exp = {luz(lt[k]), f, 8'(ct[k])};
         obs = {pare, atencao, siga, fim_fase, tempo_restante};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL normal_cycle k=%0d: got %h expected %h", k, obs, exp);
         end
      end
   endtask

   task automatic test_pedestre_early_exit();
      int lt [6];
      int ct [6];
      int pd [6];
      int fm [6];
      logic [12:0] obs, exp;
      lt = '{1,1,1,2,2,0};
      ct = '{4,3,2,1,0,3};
      pd = '{1,1,1,1,1,0};
      fm = '{0,0,0,1,0,1};
      do_reset();
      enable = 1'b1;
      repeat (4) tick();
      pedestre = 1'b1;
      tick();
      pedestre = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         exp = {luz(lt[k]), fm[k][0], pd[k][0], 8'(ct[k])};
         obs = {pare, atencao, siga, fim_fase, pedido_pend, tempo_restante};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL pedestre_early k=%0d: got %h expected %h", k + 5, obs, exp);
         end
      end
   endtask

   task automatic test_pedestre_in_pare();
      logic [3:0] obs, exp;
      do_reset();
      enable   = 1'b1;
      pedestre = 1'b1;
      for (int k = 0; k < 11; k++) begin
         if (k > 0) tick();
         if (k == 4) pedestre = 1'b0;
         exp = {luz((k < 4) ? 0 : (k < 10) ? 1 : 2), 1'b0};
         obs = {pare, atencao, siga, pedido_pend};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL pedestre_in_pare k=%0d: got %h expected %h", k, obs, exp);
         end
      end
   endtask

   task automatic test_enable_toggle();
      int lt [10];
      int ct [10];
      logic [11:0] obs, exp;
      lt = '{0,0,0,0,0,0,1,1,1,1};
      ct = '{2,2,1,1,0,0,5,5,4,4};
      do_reset();
      for (int k = 0; k < 10; k++) begin
         enable = (k % 2 == 0);
         tick();
         exp = {luz(lt[k]), (k == 6), 8'(ct[k])};
         obs = {pare, atencao, siga, fim_fase, tempo_restante};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL enable_toggle k=%0d: got %h expected %h", k + 1, obs, exp);
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_noturno();
      logic [12:0] tab [9];
      logic [12:0] obs;
      // {pare, atencao, siga, fim, pend, cnt}
      tab = '{ {3'b001, 1'b0, 1'b1, 8'd3},
               {3'b010, 1'b1, 1'b0, 8'd1},
               {3'b010, 1'b0, 1'b0, 8'd0},
               {3'b000, 1'b0, 1'b0, 8'd1},
               {3'b000, 1'b0, 1'b0, 8'd0},
               {3'b010, 1'b0, 1'b0, 8'd1},
               {3'b100, 1'b1, 1'b0, 8'd3},
               {3'b010, 1'b1, 1'b0, 8'd1},
               {3'b010, 1'b0, 1'b0, 8'd1} };
      do_reset();
      enable = 1'b1;
      repeat (4) tick();
      pedestre = 1'b1;
      tick();
      pedestre = 1'b0;
      tick();
      for (int k = 0; k < 10; k++) begin
         if (k == 7) begin
            noturno = 1'b0;
            tick();
            obs = {pare, atencao, siga, fim_fase, pedido_pend, tempo_restante};
            checks++;
            if (obs !== {3'b100, 1'b1, 1'b0, 8'd3}) begin
               errors++;
               $display("FAIL noturno_exit_disabled: got %h expected %h", obs, {3'b100, 1'b1, 1'b0, 8'd3});
            end
            break;
         end
         if (k == 1) noturno = 1'b1;
         if (k == 6) noturno = 1'b0;
         if (k == 7) enable = 1'b0;
         if (k > 0) tick();
         if (k == 6) begin
            enable  = 1'b0;
            noturno = 1'b1;
         end
         obs = {pare, atencao, siga, fim_fase, pedido_pend, tempo_restante};
         checks++;
         if (obs !== tab[k]) begin
            errors++;
            $display("FAIL noturno k=%0d: got %h expected %h", k, obs, tab[k]);
         end
         if (k == 6) begin
            tick();
            obs = {pare, atencao, siga, fim_fase, pedido_pend, tempo_restante};
            checks++;
            if (obs !== tab[7]) begin
               errors++;
               $display("FAIL noturno_entry_disabled: got %h expected %h", obs, tab[7]);
            end
            tick();
            obs = {pare, atencao, siga, fim_fase, pedido_pend, tempo_restante};
            checks++;
            if (obs !== tab[8]) begin
               errors++;
               $display("FAIL noturno_hold_disabled: got %h expected %h", obs, tab[8]);
            end
            k = 6;
         end
      end
      noturno = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [12:0] obs, exp;
      do_reset();
      enable = 1'b1;
      repeat (10) tick();
      obs = {pare, atencao, siga, fim_fase, pedido_pend, tempo_restante};
      exp = {3'b010, 1'b1, 1'b0, 8'd1};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL async_pre_atencao: got %h expected %h", obs, exp);
      end
      #2;
      reset_n = 1'b0;
      #1;
      obs = {pare, atencao, siga, fim_fase, pedido_pend, tempo_restante};
      exp = {3'b100, 1'b0, 1'b0, 8'd3};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL async_reset: got %h expected %h", obs, exp);
      end
      @(negedge clk_2);
      reset_n = 1'b1;
   endtask

   task automatic test_random_onehot();
      logic nt;
      logic [2:0] l;
      int bad;
      do_reset();
      bad = 0;
      for (int i = 0; i < 400; i++) begin
         enable   = ($urandom_range(0, 3) != 0);
         pedestre = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 24) == 0) noturno = ~noturno;
         nt = noturno;
         tick();
         l = {pare, atencao, siga};
         checks++;
         if (nt ? (l[2] | l[0]) : ($countones(l) != 1)) begin
            errors++;
            if (bad < 5) $display("FAIL random_lights i=%0d noturno=%0b: got %b", i, nt, l);
            bad++;
         end
      end
      noturno  = 1'b0;
      pedestre = 1'b0;
   endtask

   initial begin
      test_reset();
      test_normal_cycle();
      test_pedestre_early_exit();
      test_pedestre_in_pare();
      test_enable_toggle();
      test_noturno();
      test_async_reset();
      test_random_onehot();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
